// File: rtl/adpll_lock_ctrl_if.sv
// Control/status bundle between the ADPLL lock sequencer and the rest of the loop.
// The sequencer sits on the slave side; whoever drives mode/start/phase_err is the master.
interface adpll_lock_ctrl_if #(
  parameter int PERR_W = 12
);
  logic [1:0]               mode;
  logic                     start;
  logic signed [PERR_W-1:0] phase_err;
  logic                     dco_pd;
  logic                     tdc_pd;
  logic [1:0]               bank_sel;
  logic [1:0]               loop_gain;
  logic                     channel_lock;
  logic                     lock_fail;
  logic                     tx_en;
  logic [2:0]               state;

  modport master (
    output mode, start, phase_err,
    input  dco_pd, tdc_pd, bank_sel, loop_gain, channel_lock, lock_fail, tx_en, state
  );

  modport slave (
    input  mode, start, phase_err,
    output dco_pd, tdc_pd, bank_sel, loop_gain, channel_lock, lock_fail, tx_en, state
  );
endinterface

// File: rtl/adpll_lock_ctrl.sv
// ADPLL lock-acquisition sequencer: power-up, coarse/medium/fine tuning with falling
// loop gain, lock detection on a sustained small phase error, and TX gating.
//
// state  | meaning
// IDLE   | DCO/TDC powered down, waiting for start
// WARMUP | DCO/TDC powered, settling before tuning
// PVT    | coarse bank c_l, highest loop gain
// ACQ    | medium bank c_m, medium loop gain
// TRK    | fine bank c_s, counting in-window cycles toward lock
// LOCK   | channel locked, TX modulation allowed
// FAIL   | no lock within the tracking timeout
module adpll_lock_ctrl #(
  parameter int PERR_W      = 12,
  parameter int WARMUP_CYC  = 16,
  parameter int SETTLE_CYC  = 64,
  parameter int LOCK_TH     = 8,
  parameter int LOCK_CNT    = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic              clk,
  input logic              rst_n,
  adpll_lock_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WARMUP = 3'd1,
    S_PVT    = 3'd2,
    S_ACQ    = 3'd3,
    S_TRK    = 3'd4,
    S_LOCK   = 3'd5,
    S_FAIL   = 3'd6
  } state_t;

  localparam int AW      = PERR_W + 1;
  localparam int TMR_MAX = (WARMUP_CYC > SETTLE_CYC) ? WARMUP_CYC : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int IN_W    = $clog2(LOCK_CNT + 1);
  localparam int TMO_W   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [TMR_W-1:0] WARM_LD = TMR_W'(WARMUP_CYC - 1);
  localparam logic [TMR_W-1:0] SETL_LD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [IN_W-1:0]  IN_TC   = IN_W'(LOCK_CNT);
  localparam logic [TMO_W-1:0] TMO_TC  = TMO_W'(TIMEOUT_CYC);
  localparam logic [AW-1:0]    TH_IN   = AW'(LOCK_TH);
  localparam logic [AW-1:0]    TH_OUT  = AW'(4 * LOCK_TH);
  localparam logic [1:0]       MODE_PD = 2'd0;
  localparam logic [1:0]       MODE_TX = 2'd3;

  state_t            st;
  state_t            nxt;
  logic [TMR_W-1:0]  tmr;
  logic [IN_W-1:0]   in_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [AW-1:0]     pe_ext;
  logic [AW-1:0]     abs_err;
  logic              in_win;
  logic              out_lock;
  logic              pd_req;
  logic              restart;
  logic              load;

  // One extra bit so the most negative error has a representable magnitude.
  assign pe_ext   = {bus.phase_err[PERR_W-1], bus.phase_err};
  assign abs_err  = pe_ext[AW-1] ? (~pe_ext + 1'b1) : pe_ext;
  assign in_win   = (abs_err <= TH_IN);
  assign out_lock = (abs_err > TH_OUT);
  assign pd_req   = (bus.mode == MODE_PD);
  assign restart  = bus.start && !pd_req;
  assign load     = (nxt != st) || restart;
  assign bus.state = st;

  always_comb begin
    nxt = st;
    if (pd_req) begin
      nxt = S_IDLE;
    end else if (bus.start) begin
      nxt = S_WARMUP;
    end else begin
      case (st)
        S_WARMUP: if (tmr == '0) nxt = S_PVT;
        S_PVT:    if (tmr == '0) nxt = S_ACQ;
        S_ACQ:    if (tmr == '0) nxt = S_TRK;
        S_TRK: begin
          // Lock takes precedence when both limits are reached together.
          if (in_cnt == IN_TC)         nxt = S_LOCK;
          else if (tmo_cnt == TMO_TC)  nxt = S_FAIL;
        end
        S_LOCK:   if (out_lock) nxt = S_TRK;
        default:  nxt = st;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st               <= S_IDLE;
      tmr              <= '0;
      in_cnt           <= '0;
      tmo_cnt          <= '0;
      bus.dco_pd       <= 1'b1;
      bus.tdc_pd       <= 1'b1;
      bus.bank_sel     <= 2'd0;
      bus.loop_gain    <= 2'd0;
      bus.channel_lock <= 1'b0;
      bus.lock_fail    <= 1'b0;
      bus.tx_en        <= 1'b0;
    end else begin
      st <= nxt;
      if (load) begin
        in_cnt  <= '0;
        tmo_cnt <= '0;
        case (nxt)
          S_WARMUP:     tmr <= WARM_LD;
          S_PVT, S_ACQ: tmr <= SETL_LD;
          default:      tmr <= '0;
        endcase
      end else begin
        if (tmr != '0) tmr <= tmr - 1'b1;
        if (st == S_TRK) begin
          if (!in_win)              in_cnt <= '0;
          else if (in_cnt != IN_TC) in_cnt <= in_cnt + 1'b1;
          if (tmo_cnt != TMO_TC)    tmo_cnt <= tmo_cnt + 1'b1;
        end
      end

      // Outputs decode the state being entered so they change on the same edge.
      bus.dco_pd       <= (nxt == S_IDLE);
      bus.tdc_pd       <= (nxt == S_IDLE);
      bus.channel_lock <= (nxt == S_LOCK);
      bus.lock_fail    <= (nxt == S_FAIL);
      bus.tx_en        <= (nxt == S_LOCK) && (bus.mode == MODE_TX);
      bus.bank_sel     <= 2'd0;
      bus.loop_gain    <= 2'd0;
      case (nxt)
        S_PVT:  begin bus.bank_sel <= 2'd1; bus.loop_gain <= 2'd3; end
        S_ACQ:  begin bus.bank_sel <= 2'd2; bus.loop_gain <= 2'd2; end
        S_TRK:  begin bus.bank_sel <= 2'd3; bus.loop_gain <= 2'd1; end
        S_LOCK: begin bus.bank_sel <= 2'd3; bus.loop_gain <= 2'd0; end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adpll_lock_ctrl.sv
// Scoreboard bench for adpll_lock_ctrl: each scenario schedules stimulus and expected
// output snapshots by cycle number, then walks the clock comparing them.
module tb_adpll_lock_ctrl;
  localparam logic [2:0] S_IDLE = 3'd0, S_WARMUP = 3'd1, S_PVT = 3'd2, S_ACQ = 3'd3,
                         S_TRK = 3'd4, S_LOCK = 3'd5, S_FAIL = 3'd6;
  localparam logic [1:0] M_PD = 2'd0, M_RX = 2'd2, M_TX = 2'd3;

  typedef struct {
    int                 at;
    logic [1:0]         mode;
    logic               start;
    logic signed [11:0] pe;
  } stim_t;

  typedef struct {
    int          at;
    logic [12:0] v;
    string       tag;
  } exp_t;

  logic  clk   = 1'b0;
  logic  rst_n = 1'b1;
  int    cyc    = 0;
  int    n_chk  = 0;
  int    n_fail = 0;
  stim_t sq[$];
  exp_t  eq[$];

  adpll_lock_ctrl_if #(.PERR_W(12)) bus ();

  adpll_lock_ctrl #(.PERR_W(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected output snapshot for a state, straight from the output table.
  function automatic logic [12:0] exp_vec(input logic [2:0] s, input logic tx);
    logic pd, lk, fl;
    logic [1:0] bk, gn;
    pd = 1'b0; lk = 1'b0; fl = 1'b0; bk = 2'd0; gn = 2'd0;
    case (s)
      S_IDLE: pd = 1'b1;
      S_PVT:  begin bk = 2'd1; gn = 2'd3; end
      S_ACQ:  begin bk = 2'd2; gn = 2'd2; end
      S_TRK:  begin bk = 2'd3; gn = 2'd1; end
      S_LOCK: begin bk = 2'd3; lk = 1'b1; end
      S_FAIL: fl = 1'b1;
      default: ;
    endcase
    return {s, pd, pd, bk, gn, lk, fl, tx & lk};
  endfunction

  function automatic logic [12:0] obs();
    return {bus.state, bus.dco_pd, bus.tdc_pd, bus.bank_sel, bus.loop_gain,
            bus.channel_lock, bus.lock_fail, bus.tx_en};
  endfunction

  // Input values take effect at the edge numbered 'at'.
  task automatic drv(input int at, input logic [1:0] m, input logic s, input logic signed [11:0] p);
    sq.push_back('{at: at, mode: m, start: s, pe: p});
  endtask

  task automatic expect_at(input int at, input logic [2:0] s, input logic tx, input string tag);
    eq.push_back('{at: at, v: exp_vec(s, tx), tag: tag});
  endtask

  task automatic test_reset();
    bus.mode = M_PD; bus.start = 1'b0; bus.phase_err = '0;
    #1 rst_n = 1'b0;
    #2;
    n_chk++;
    if (obs() !== exp_vec(S_IDLE, 1'b0)) begin
      n_fail++;
      $display("FAIL reset_values: got %h, expected %h", obs(), exp_vec(S_IDLE, 1'b0));
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (obs() !== exp_vec(S_IDLE, 1'b0)) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %h, expected %h", obs(), exp_vec(S_IDLE, 1'b0));
    end
  endtask

  task automatic test_lock_seq();
    int t0;
    t0 = cyc + 2;
    drv(t0, M_TX, 1'b1, 12'sd0);
    drv(t0 + 1, M_TX, 1'b0, 12'sd0);
    expect_at(t0,       S_WARMUP, 1'b0, "warmup_entry");
    expect_at(t0 + 15,  S_WARMUP, 1'b0, "warmup_last");
    expect_at(t0 + 16,  S_PVT,    1'b0, "pvt_entry");
    expect_at(t0 + 79,  S_PVT,    1'b0, "pvt_last");
    expect_at(t0 + 80,  S_ACQ,    1'b0, "acq_entry");
    expect_at(t0 + 143, S_ACQ,    1'b0, "acq_last");
    expect_at(t0 + 144, S_TRK,    1'b0, "trk_entry");
    expect_at(t0 + 176, S_TRK,    1'b0, "trk_last");
    expect_at(t0 + 177, S_LOCK,   1'b1, "lock_tx");
    while (eq.size() > 0) begin
      while (sq.size() > 0 && sq[0].at - 1 <= cyc) begin
        bus.mode = sq[0].mode; bus.start = sq[0].start; bus.phase_err = sq[0].pe;
        void'(sq.pop_front());
      end
      if (eq[0].at <= cyc) begin
        n_chk++;
        if (eq[0].at < cyc || obs() !== eq[0].v) begin
          n_fail++;
          $display("FAIL %s (cycle %0d): got %h, expected %h", eq[0].tag, cyc, obs(), eq[0].v);
        end
        void'(eq.pop_front());
      end else @(negedge clk);
    end
  endtask

  task automatic test_trk_window();
    int t0;
    t0 = cyc + 2;
    drv(t0,       M_TX, 1'b1, 12'sd0);
    drv(t0 + 1,   M_TX, 1'b0, 12'sd0);
    drv(t0 + 176, M_TX, 1'b0, 12'sd9);
    drv(t0 + 177, M_TX, 1'b0, 12'sd0);
    drv(t0 + 208, M_TX, 1'b0, -12'sd2048);
    drv(t0 + 209, M_TX, 1'b0, 12'sd8);
    drv(t0 + 225, M_TX, 1'b0, -12'sd8);
    expect_at(t0,       S_WARMUP, 1'b0, "restart_from_lock");
    expect_at(t0 + 176, S_TRK,    1'b0, "glitch_p9");
    expect_at(t0 + 177, S_TRK,    1'b0, "no_lock_after_p9");
    expect_at(t0 + 208, S_TRK,    1'b0, "glitch_m2048");
    expect_at(t0 + 209, S_TRK,    1'b0, "no_lock_after_m2048");
    expect_at(t0 + 240, S_TRK,    1'b0, "edge_window_pre");
    expect_at(t0 + 241, S_LOCK,   1'b1, "lock_at_pm8");
    while (eq.size() > 0) begin
      while (sq.size() > 0 && sq[0].at - 1 <= cyc) begin
        bus.mode = sq[0].mode; bus.start = sq[0].start; bus.phase_err = sq[0].pe;
        void'(sq.pop_front());
      end
      if (eq[0].at <= cyc) begin
        n_chk++;
        if (eq[0].at < cyc || obs() !== eq[0].v) begin
          n_fail++;
          $display("FAIL %s (cycle %0d): got %h, expected %h", eq[0].tag, cyc, obs(), eq[0].v);
        end
        void'(eq.pop_front());
      end else @(negedge clk);
    end
  endtask

  task automatic test_lock_exit();
    int b;
    b = cyc;
    drv(b + 2,  M_TX, 1'b0, 12'sd32);
    drv(b + 3,  M_TX, 1'b0, -12'sd32);
    drv(b + 4,  M_TX, 1'b0, 12'sd33);
    drv(b + 5,  M_TX, 1'b0, 12'sd0);
    drv(b + 39, M_TX, 1'b0, -12'sd33);
    drv(b + 40, M_TX, 1'b0, 12'sd0);
    expect_at(b + 2,  S_LOCK, 1'b1, "hold_p32");
    expect_at(b + 3,  S_LOCK, 1'b1, "hold_m32");
    expect_at(b + 4,  S_TRK,  1'b0, "exit_p33");
    expect_at(b + 36, S_TRK,  1'b0, "relock_pre");
    expect_at(b + 37, S_LOCK, 1'b1, "relock");
    expect_at(b + 39, S_TRK,  1'b0, "exit_m33");
    expect_at(b + 72, S_LOCK, 1'b1, "relock2");
    while (eq.size() > 0) begin
      while (sq.size() > 0 && sq[0].at - 1 <= cyc) begin
        bus.mode = sq[0].mode; bus.start = sq[0].start; bus.phase_err = sq[0].pe;
        void'(sq.pop_front());
      end
      if (eq[0].at <= cyc) begin
        n_chk++;
        if (eq[0].at < cyc || obs() !== eq[0].v) begin
          n_fail++;
          $display("FAIL %s (cycle %0d): got %h, expected %h", eq[0].tag, cyc, obs(), eq[0].v);
        end
        void'(eq.pop_front());
      end else @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    int t0, t1;
    t0 = cyc + 2;
    t1 = t0 + 1192;
    drv(t0,        M_TX, 1'b1, 12'sd100);
    drv(t0 + 1,    M_TX, 1'b0, 12'sd100);
    drv(t1,        M_TX, 1'b1, 12'sd100);
    drv(t1 + 1,    M_TX, 1'b0, 12'sd100);
    drv(t1 + 1137, M_TX, 1'b0, 12'sd0);
    expect_at(t0 + 144,  S_TRK,    1'b0, "tmo_trk_entry");
    expect_at(t0 + 1168, S_TRK,    1'b0, "tmo_pre");
    expect_at(t0 + 1169, S_FAIL,   1'b0, "tmo_fail");
    expect_at(t0 + 1190, S_FAIL,   1'b0, "fail_hold");
    expect_at(t1,        S_WARMUP, 1'b0, "fail_restart");
    expect_at(t1 + 1168, S_TRK,    1'b0, "tie_pre");
    expect_at(t1 + 1169, S_LOCK,   1'b1, "tie_lock_wins");
    while (eq.size() > 0) begin
      while (sq.size() > 0 && sq[0].at - 1 <= cyc) begin
        bus.mode = sq[0].mode; bus.start = sq[0].start; bus.phase_err = sq[0].pe;
        void'(sq.pop_front());
      end
      if (eq[0].at <= cyc) begin
        n_chk++;
        if (eq[0].at < cyc || obs() !== eq[0].v) begin
          n_fail++;
          $display("FAIL %s (cycle %0d): got %h, expected %h", eq[0].tag, cyc, obs(), eq[0].v);
        end
        void'(eq.pop_front());
      end else @(negedge clk);
    end
  endtask

  task automatic test_power_down();
    int t0;
    t0 = cyc + 2;
    drv(t0,       M_RX, 1'b1, 12'sd0);
    drv(t0 + 1,   M_RX, 1'b0, 12'sd0);
    drv(t0 + 100, M_PD, 1'b0, 12'sd0);
    drv(t0 + 103, M_PD, 1'b1, 12'sd0);
    drv(t0 + 104, M_PD, 1'b0, 12'sd0);
    expect_at(t0 + 80,  S_ACQ,  1'b0, "pd_acq_entry");
    expect_at(t0 + 99,  S_ACQ,  1'b0, "pd_acq_before");
    expect_at(t0 + 100, S_IDLE, 1'b0, "pd_from_acq");
    expect_at(t0 + 103, S_IDLE, 1'b0, "pd_blocks_start");
    expect_at(t0 + 106, S_IDLE, 1'b0, "pd_stays_idle");
    while (eq.size() > 0) begin
      while (sq.size() > 0 && sq[0].at - 1 <= cyc) begin
        bus.mode = sq[0].mode; bus.start = sq[0].start; bus.phase_err = sq[0].pe;
        void'(sq.pop_front());
      end
      if (eq[0].at <= cyc) begin
        n_chk++;
        if (eq[0].at < cyc || obs() !== eq[0].v) begin
          n_fail++;
          $display("FAIL %s (cycle %0d): got %h, expected %h", eq[0].tag, cyc, obs(), eq[0].v);
        end
        void'(eq.pop_front());
      end else @(negedge clk);
    end
  endtask

  task automatic test_rx_and_async_reset();
    int t0;
    t0 = cyc + 2;
    drv(t0,       M_RX, 1'b1, 12'sd0);
    drv(t0 + 1,   M_RX, 1'b0, 12'sd0);
    drv(t0 + 179, M_TX, 1'b0, 12'sd0);
    drv(t0 + 181, M_RX, 1'b0, 12'sd0);
    expect_at(t0 + 177, S_LOCK, 1'b0, "rx_lock_no_tx");
    expect_at(t0 + 179, S_LOCK, 1'b1, "rx_to_tx");
    expect_at(t0 + 181, S_LOCK, 1'b0, "tx_to_rx");
    while (eq.size() > 0) begin
      while (sq.size() > 0 && sq[0].at - 1 <= cyc) begin
        bus.mode = sq[0].mode; bus.start = sq[0].start; bus.phase_err = sq[0].pe;
        void'(sq.pop_front());
      end
      if (eq[0].at <= cyc) begin
        n_chk++;
        if (eq[0].at < cyc || obs() !== eq[0].v) begin
          n_fail++;
          $display("FAIL %s (cycle %0d): got %h, expected %h", eq[0].tag, cyc, obs(), eq[0].v);
        end
        void'(eq.pop_front());
      end else @(negedge clk);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (obs() !== exp_vec(S_IDLE, 1'b0)) begin
      n_fail++;
      $display("FAIL async_reset_in_lock: got %h, expected %h", obs(), exp_vec(S_IDLE, 1'b0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (obs() !== exp_vec(S_IDLE, 1'b0)) begin
      n_fail++;
      $display("FAIL idle_after_async_reset: got %h, expected %h", obs(), exp_vec(S_IDLE, 1'b0));
    end
  endtask

  initial begin
    test_reset();
    test_lock_seq();
    test_trk_window();
    test_lock_exit();
    test_timeout();
    test_power_down();
    test_rx_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
